// File: rtl/bcd_timer_pkg.sv
// Shared constants and helpers for the two-digit BCD timer controller.
package bcd_timer_pkg;

  // FSM state encoding (visible on the state output)
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // BCD digit limits
  localparam logic [3:0] BCD_MIN = 4'd0;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Clamp a nibble into the legal BCD range.
  function automatic logic [3:0] bcd_sat_nib(input logic [3:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

  // Value the two-digit count takes after one step in the given direction.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic dn);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = v[3:0];
    tens = v[7:4];
    if (dn) begin
      if (ones == BCD_MIN) begin
        ones = BCD_MAX;
        tens = (tens == BCD_MIN) ? BCD_MAX : tens - 4'd1;
      end else begin
        ones = ones - 4'd1;
      end
    end else begin
      if (ones == BCD_MAX) begin
        ones = BCD_MIN;
        tens = (tens == BCD_MAX) ? BCD_MIN : tens + 4'd1;
      end else begin
        ones = ones + 4'd1;
      end
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD decade: synchronous load, enabled up/down step, roll-over flag.
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  input  logic       en_i,
  input  logic       dn_i,
  output logic [3:0] q_o,
  output logic       co_o
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: load wins over step, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (en_i) begin
      if (dn_i) q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      else      q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= BCD_MIN;
    else       q_q <= q_d;
  end

  // Carry (up) / borrow (down): the next step in this direction rolls over.
  assign co_o = dn_i ? (q_q == BCD_MIN) : (q_q == BCD_MAX);
  assign q_o  = q_q;

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD up/down timer with IDLE/RUN/PAUSE/DONE command FSM.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter logic [7:0] TERM_UP = 8'h99
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] preset,
  input  logic       down,
  output logic [7:0] count,
  output logic [1:0] state,
  output logic       done,
  output logic       running
);

  logic [1:0] state_q, state_d;
  logic       done_q, done_d;
  logic       run_q, run_d;
  logic       dir_q, dir_d;

  logic       cnt_ld;
  logic [7:0] cnt_ld_val;
  logic       cnt_step;
  logic [7:0] cnt;
  logic       ones_co, tens_co;
  logic [7:0] san_val;
  logic [7:0] term_run;
  logic [7:0] term_start;

  assign term_run   = dir_q ? 8'h00 : TERM_UP;
  assign term_start = down  ? 8'h00 : TERM_UP;

  // Preset sanitizing: clamp each nibble to 9, then the whole value to TERM_UP.
  always_comb begin
    san_val = {bcd_sat_nib(preset[7:4]), bcd_sat_nib(preset[3:0])};
    if (san_val > TERM_UP) san_val = TERM_UP;
  end

  // Command decode in priority order clear > load > stop > start > tick.
  // A load ignored in RUN does not mask the lower-priority commands.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    cnt_step   = 1'b0;
    if (clear) begin
      cnt_ld  = 1'b1;
      state_d = ST_IDLE;
      dir_d   = 1'b0;
    end else if (load && state_q != ST_RUN) begin
      cnt_ld     = 1'b1;
      cnt_ld_val = san_val;
      state_d    = ST_IDLE;
    end else if (stop && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
      dir_d = down;
      if (cnt == term_start) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (tick && state_q == ST_RUN) begin
      // Never roll past 99/00; the terminal check normally stops us first.
      cnt_step = !(ones_co && tens_co);
      if (bcd_step(cnt, dir_q) == term_run) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
    run_d = (state_d == ST_RUN);
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      run_q   <= run_d;
      dir_q   <= dir_d;
    end
  end

  bcd_digit u_ones (
    .clk_i    (clk),
    .rst_i    (reset),
    .ld_i     (cnt_ld),
    .ld_val_i (cnt_ld_val[3:0]),
    .en_i     (cnt_step),
    .dn_i     (dir_q),
    .q_o      (cnt[3:0]),
    .co_o     (ones_co)
  );

  bcd_digit u_tens (
    .clk_i    (clk),
    .rst_i    (reset),
    .ld_i     (cnt_ld),
    .ld_val_i (cnt_ld_val[7:4]),
    .en_i     (cnt_step && ones_co),
    .dn_i     (dir_q),
    .q_o      (cnt[7:4]),
    .co_o     (tens_co)
  );

  assign count   = cnt;
  assign state   = state_q;
  assign done    = done_q;
  assign running = run_q;

endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter TERM_UP, default 8'h99, is the up-mode terminal count as two BCD digits; it SHALL be valid BCD (each nibble 0-9).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  count-enable strobe; one count step per cycle sampled high.
REQ-006 start  input  1  begin or resume counting.
REQ-007 stop  input  1  pause counting.
REQ-008 clear  input  1  return to IDLE with count 8'h00.
REQ-009 load  input  1  load preset into count.
REQ-010 preset  input  8  BCD load value: [7:4] tens, [3:0] ones.
REQ-011 down  input  1  direction: 0 up, 1 down; latched on start.
REQ-012 count  output  8  current BCD count: [7:4] tens, [3:0] ones.
REQ-013 state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-014 done  output  1  one-cycle pulse when the terminal count is reached.
REQ-015 running  output  1  high exactly when state is RUN.

Function
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE and DONE, with command priority clear > load > stop > start > tick within a cycle.
REQ-017 clear in any state SHALL set count to 8'h00, state to IDLE and the latched direction to up on the next edge.
REQ-018 load in IDLE, PAUSE or DONE SHALL load preset and enter IDLE; load in RUN SHALL be ignored.
REQ-019 Load sanitizing: any preset nibble above 9 SHALL load as 9, and a sanitized value above TERM_UP SHALL load as TERM_UP.
REQ-020 start in IDLE or PAUSE SHALL latch down and enter RUN, or enter DONE with done asserted if count already equals the terminal (TERM_UP when up, 8'h00 when down).
REQ-021 start in RUN or DONE SHALL be ignored; down changes while not sampled by start SHALL be ignored.
REQ-022 stop in RUN SHALL enter PAUSE with count held; stop in other states SHALL be ignored.
REQ-023 In RUN, tick SHALL step count by one BCD unit on the same edge; tick outside RUN SHALL be ignored.
REQ-024 Up step: ones 9 wraps to 0 and increments tens; otherwise ones increments.
REQ-025 Down step: ones 0 wraps to 9 and decrements tens; otherwise ones decrements.
REQ-026 The edge that makes count equal the terminal SHALL also set state to DONE and done high for exactly that following cycle; latency from tick to done is 1 clock.
REQ-027 DONE SHALL hold count until clear or load.
REQ-028 count SHALL never hold a nibble above 9 and SHALL never exceed TERM_UP.

Reset
REQ-029 reset SHALL force, asynchronously: count=8'h00, state=IDLE, done=0, running=0, latched direction=up.
REQ-030 Reset asserted mid-RUN SHALL abandon the count; after release the block SHALL respond to commands on the first rising edge.

Structure
REQ-031 Package bcd_timer_pkg SHALL hold the state encoding constants and the BCD digit limits (0, 9).
REQ-032 One sub-module, bcd_digit, SHALL implement a single decade with load, enable, up/down, and carry/borrow out; two instances SHALL form count.
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 Reset, load preset=8'h97, start with down=0, three ticks -> count 98, 99; done high one cycle at 99 with state=DONE; third tick ignored, count stays 99.
REQ-035 Load 8'h10, start with down=1, ticks -> count 09 (borrow), then down to 00; done pulses once and state=DONE.
REQ-036 RUN at 8'h42, assert stop and tick in the same cycle -> state PAUSE, count stays 42; start then tick -> RUN, count 43.
REQ-037 Load 8'hAF -> count 99; with TERM_UP=8'h59, load 8'h75 -> count 59; start up -> immediate DONE with done pulse.
REQ-038 Assert clear and load together in PAUSE -> count 00, state IDLE; assert reset mid-RUN at 8'h35 -> count 00 immediately, without waiting for a clock edge.
